// File: rtl/trig_link_char_scheduler.sv
// Trigger-link slot scheduler: picks IDLE/L1A/BC0/RESYNC/data per frame slot for the 6b/8b encoder.
// Latency: request or FIFO write is eligible at the next frame_en slot; outputs registered, held between slots.
// Backpressure: data_ready drops when the FIFO is full; repeated unserved commands coalesce and are counted.

module trig_link_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 6
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en, rd_en;

    assign wr_rdy = (count_q != CW'(DEPTH));
    assign rd_vld = (count_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = count_q;
    assign wr_en  = wr_vld & wr_rdy;
    assign rd_en  = rd_rdy & rd_vld;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
    end
endmodule

module trig_link_char_scheduler #(
    parameter int FIFO_DEPTH  = 8,
    parameter int IDLE_PERIOD = 64,
    parameter int IDLE_BURST  = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          frame_en,
    input  logic                          link_restart,
    input  logic [5:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic                          l1a_req,
    input  logic                          bc0_req,
    input  logic                          resync_req,
    output logic                          enc_l1a,
    output logic                          enc_bc0,
    output logic                          enc_resync,
    output logic                          enc_idle,
    output logic [5:0]                    enc_sixbit,
    output logic [7:0]                    cmd_drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(IDLE_PERIOD);
    localparam int BW = $clog2(IDLE_BURST + 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(IDLE_PERIOD - 1);
    localparam logic [BW-1:0] BURST_LAST  = BW'(IDLE_BURST - 1);

    localparam logic [0:0] ST_STARTUP = 1'b0;
    localparam logic [0:0] ST_RUN     = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [PW-1:0] period_q, period_d;
    logic          l1a_p_q, l1a_p_d, bc0_p_q, bc0_p_d, resync_p_q, resync_p_d;
    logic          idle_q, idle_d, l1a_q, l1a_d, bc0_q, bc0_d, resync_q, resync_d;
    logic [5:0]    sixbit_q, sixbit_d;
    logic [7:0]    drop_q, drop_d;
    logic          srv_l1a, srv_bc0, srv_resync, pop;
    logic          fifo_vld;
    logic [5:0]    fifo_dat;
    logic [1:0]    drop_inc;
    logic [8:0]    drop_sum;

    trig_link_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(6)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_vld  (data_valid),
        .wr_rdy  (data_ready),
        .wr_dat  (data_in),
        .rd_rdy  (pop),
        .rd_vld  (fifo_vld),
        .rd_dat  (fifo_dat),
        .count   (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        period_d   = period_q;
        idle_d     = idle_q;
        l1a_d      = l1a_q;
        bc0_d      = bc0_q;
        resync_d   = resync_q;
        sixbit_d   = sixbit_q;
        srv_l1a    = 1'b0;
        srv_bc0    = 1'b0;
        srv_resync = 1'b0;
        pop        = 1'b0;

        // Restart pre-empts the slot: current outputs hold until the next frame_en.
        if (link_restart) begin
            state_d  = ST_STARTUP;
            burst_d  = '0;
            period_d = '0;
        end else if (frame_en) begin
            idle_d   = 1'b0;
            l1a_d    = 1'b0;
            bc0_d    = 1'b0;
            resync_d = 1'b0;
            sixbit_d = '0;
            if (state_q == ST_STARTUP) begin
                idle_d = 1'b1;
                if (burst_q == BURST_LAST) begin
                    state_d  = ST_RUN;
                    burst_d  = '0;
                    period_d = '0;
                end else begin
                    burst_d = burst_q + 1'b1;
                end
            end else begin
                period_d = (period_q == PERIOD_LAST) ? '0 : period_q + 1'b1;
                if (period_q == PERIOD_LAST) begin
                    idle_d = 1'b1;
                end else if (l1a_p_q) begin
                    l1a_d   = 1'b1;
                    srv_l1a = 1'b1;
                end else if (bc0_p_q) begin
                    bc0_d   = 1'b1;
                    srv_bc0 = 1'b1;
                end else if (resync_p_q) begin
                    resync_d   = 1'b1;
                    srv_resync = 1'b1;
                end else if (fifo_vld) begin
                    pop      = 1'b1;
                    sixbit_d = fifo_dat;
                end else begin
                    idle_d = 1'b1;
                end
            end
        end
    end

    // A request landing on its own serve slot re-arms the flag rather than counting as a drop.
    always_comb begin
        l1a_p_d    = (l1a_p_q & ~srv_l1a) | l1a_req;
        bc0_p_d    = (bc0_p_q & ~srv_bc0) | bc0_req;
        resync_p_d = (resync_p_q & ~srv_resync) | resync_req;
        drop_inc   = {1'b0, l1a_req & l1a_p_q & ~srv_l1a}
                   + {1'b0, bc0_req & bc0_p_q & ~srv_bc0}
                   + {1'b0, resync_req & resync_p_q & ~srv_resync};
        drop_sum   = {1'b0, drop_q} + {7'd0, drop_inc};
        drop_d     = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_STARTUP;
            burst_q    <= '0;
            period_q   <= '0;
            l1a_p_q    <= 1'b0;
            bc0_p_q    <= 1'b0;
            resync_p_q <= 1'b0;
            idle_q     <= 1'b1;
            l1a_q      <= 1'b0;
            bc0_q      <= 1'b0;
            resync_q   <= 1'b0;
            sixbit_q   <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            period_q   <= period_d;
            l1a_p_q    <= l1a_p_d;
            bc0_p_q    <= bc0_p_d;
            resync_p_q <= resync_p_d;
            idle_q     <= idle_d;
            l1a_q      <= l1a_d;
            bc0_q      <= bc0_d;
            resync_q   <= resync_d;
            sixbit_q   <= sixbit_d;
            drop_q     <= drop_d;
        end
    end

    assign enc_idle     = idle_q;
    assign enc_l1a      = l1a_q;
    assign enc_bc0      = bc0_q;
    assign enc_resync   = resync_q;
    assign enc_sixbit   = sixbit_q;
    assign cmd_drop_cnt = drop_q;
endmodule

// File: tb/tb_trig_link_char_scheduler.sv
// Bench for trig_link_char_scheduler: directed scenarios plus random traffic against a queue-based slot model.
module tb_trig_link_char_scheduler;
    localparam int DEPTH  = 8;
    localparam int PERIOD = 64;
    localparam int BURST  = 4;

    localparam logic [9:0] V_IDLE   = 10'h200;
    localparam logic [9:0] V_L1A    = 10'h100;
    localparam logic [9:0] V_BC0    = 10'h080;
    localparam logic [9:0] V_RESYNC = 10'h040;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_en = 1'b0, link_restart = 1'b0;
    logic [5:0] data_in = '0;
    logic       data_valid = 1'b0, data_ready;
    logic       l1a_req = 1'b0, bc0_req = 1'b0, resync_req = 1'b0;
    logic       enc_l1a, enc_bc0, enc_resync, enc_idle;
    logic [5:0] enc_sixbit;
    logic [7:0] cmd_drop_cnt;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit         m_startup;
    int         m_burst, m_period, m_drop;
    bit         m_l1a, m_bc0, m_rsy;
    logic [5:0] m_q[$];
    logic [9:0] m_out;

    trig_link_char_scheduler #(.FIFO_DEPTH(DEPTH), .IDLE_PERIOD(PERIOD), .IDLE_BURST(BURST)) dut (
        .clock(clock), .reset_n(reset_n), .frame_en(frame_en), .link_restart(link_restart),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .l1a_req(l1a_req), .bc0_req(bc0_req), .resync_req(resync_req),
        .enc_l1a(enc_l1a), .enc_bc0(enc_bc0), .enc_resync(enc_resync), .enc_idle(enc_idle),
        .enc_sixbit(enc_sixbit), .cmd_drop_cnt(cmd_drop_cnt), .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] obs_vec();
        return {enc_idle, enc_l1a, enc_bc0, enc_resync, enc_sixbit};
    endfunction

    task automatic model_reset();
        m_startup = 1; m_burst = 0; m_period = 0; m_drop = 0;
        m_l1a = 0; m_bc0 = 0; m_rsy = 0;
        m_q.delete();
        m_out = V_IDLE;
    endtask

    function automatic void note_req(input bit req, input bit served, inout bit flag);
        if (req) begin
            if (flag && !served && m_drop < 255) m_drop++;
            flag = 1;
        end else if (served) begin
            flag = 0;
        end
    endfunction

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_cycle();
        bit wr, s_l1a, s_bc0, s_rsy;
        wr = data_valid && (m_q.size() != DEPTH);
        s_l1a = 0; s_bc0 = 0; s_rsy = 0;
        if (link_restart) begin
            m_startup = 1; m_burst = 0; m_period = 0;
        end else if (frame_en) begin
            if (m_startup) begin
                m_out = V_IDLE;
                m_burst++;
                if (m_burst == BURST) begin m_startup = 0; m_period = 0; end
            end else begin
                if (m_period == PERIOD - 1)  m_out = V_IDLE;
                else if (m_l1a) begin m_out = V_L1A; s_l1a = 1; end
                else if (m_bc0) begin m_out = V_BC0; s_bc0 = 1; end
                else if (m_rsy) begin m_out = V_RESYNC; s_rsy = 1; end
                else if (m_q.size() > 0) m_out = {4'b0000, m_q.pop_front()};
                else m_out = V_IDLE;
                m_period = (m_period + 1) % PERIOD;
            end
        end
        note_req(l1a_req, s_l1a, m_l1a);
        note_req(bc0_req, s_bc0, m_bc0);
        note_req(resync_req, s_rsy, m_rsy);
        if (wr) m_q.push_back(data_in);
    endtask

    task automatic cyc();
        model_cycle();
        @(posedge clock);
        #1;
        check_val("out", int'(obs_vec()), int'(m_out));
        check_val("fifo_count", int'(fifo_count), m_q.size());
        check_val("data_ready", int'(data_ready), int'(m_q.size() != DEPTH));
        check_val("drop_cnt", int'(cmd_drop_cnt), m_drop);
    endtask

    task automatic slot(input logic [9:0] exp, input string tag);
        frame_en = 1;
        cyc();
        check_val(tag, int'(obs_vec()), int'(exp));
    endtask

    task automatic push_word(input logic [5:0] w);
        data_in = w; data_valid = 1;
        cyc();
        data_valid = 0;
    endtask

    initial begin
        model_reset();
        #12;
        check_val("rst_out", int'(obs_vec()), int'(V_IDLE));
        check_val("rst_count", int'(fifo_count), 0);
        check_val("rst_ready", int'(data_ready), 1);
        check_val("rst_drop", int'(cmd_drop_cnt), 0);
        reset_n = 1;

        // Startup burst, then filler idles over more than one period
        frame_en = 1;
        for (int i = 0; i < BURST; i++) slot(V_IDLE, "startup_idle");
        for (int i = 0; i < PERIOD + 6; i++) cyc();

        // Commands ahead of queued data after a fresh startup
        frame_en = 0;
        link_restart = 1; cyc(); link_restart = 0;
        push_word(6'h00); push_word(6'h15); push_word(6'h3F);
        l1a_req = 1; bc0_req = 1; cyc(); l1a_req = 0; bc0_req = 0;
        for (int i = 0; i < BURST; i++) slot(V_IDLE, "seq_burst");
        slot(V_L1A, "seq_l1a");
        slot(V_BC0, "seq_bc0");
        slot(10'h000, "seq_d00");
        slot(10'h015, "seq_d15");
        slot(10'h03F, "seq_d3f");
        slot(V_IDLE, "seq_tail");

        // Fill past capacity with no slots
        frame_en = 0;
        for (int i = 0; i < DEPTH + 1; i++) push_word(6'(i + 1));
        check_val("full_count", int'(fifo_count), DEPTH);
        check_val("full_ready", int'(data_ready), 0);
        frame_en = 1;
        for (int i = 0; i < DEPTH + 4; i++) cyc();

        // Coalesced L1A requests and saturation
        frame_en = 0;
        l1a_req = 1;
        for (int i = 0; i < 3; i++) cyc();
        check_val("drop_two", int'(cmd_drop_cnt), 2);
        for (int i = 0; i < 300; i++) cyc();
        l1a_req = 0;
        check_val("drop_sat", int'(cmd_drop_cnt), 255);
        frame_en = 1;
        for (int i = 0; i < 4; i++) cyc();

        // Asynchronous reset mid-stream
        data_valid = 1;
        for (int i = 0; i < 6; i++) begin data_in = 6'($urandom); frame_en = 1'(i & 1); cyc(); end
        data_valid = 0; frame_en = 0;
        #3 reset_n = 0;
        #1;
        check_val("mid_rst_out", int'(obs_vec()), int'(V_IDLE));
        check_val("mid_rst_count", int'(fifo_count), 0);
        check_val("mid_rst_drop", int'(cmd_drop_cnt), 0);
        model_reset();
        @(posedge clock); #1;
        reset_n = 1;

        // Forced idle pre-empts a pending command; same-slot request re-arms
        link_restart = 1; cyc(); link_restart = 0;
        frame_en = 1;
        for (int i = 0; i < BURST + PERIOD - 1; i++) cyc();
        frame_en = 0;
        resync_req = 1; cyc(); resync_req = 0;
        slot(V_IDLE, "forced_idle");
        slot(V_RESYNC, "after_forced");
        frame_en = 0;
        bc0_req = 1; cyc();
        slot(V_BC0, "bc0_first");
        bc0_req = 0;
        check_val("rearm_drop", int'(cmd_drop_cnt), 0);
        slot(V_BC0, "bc0_again");
        slot(V_IDLE, "bc0_done");

        // Restart with words and a resync queued
        frame_en = 0;
        push_word(6'h2A); push_word(6'h11);
        resync_req = 1; cyc(); resync_req = 0;
        check_val("rs_count", int'(fifo_count), 2);
        frame_en = 1; link_restart = 1; cyc(); link_restart = 0;
        for (int i = 0; i < BURST; i++) slot(V_IDLE, "rs_burst");
        slot(V_RESYNC, "rs_resync");
        slot(10'h02A, "rs_w0");
        slot(10'h011, "rs_w1");
        slot(V_IDLE, "rs_tail");

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            frame_en     = ($urandom_range(0, 99) < 55);
            data_valid   = ($urandom_range(0, 99) < 60);
            data_in      = 6'($urandom);
            l1a_req      = ($urandom_range(0, 99) < 8);
            bc0_req      = ($urandom_range(0, 99) < 8);
            resync_req   = ($urandom_range(0, 99) < 8);
            link_restart = ($urandom_range(0, 999) < 4);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/trig_link_char_scheduler.md
Name: trig_link_char_scheduler

Overview:
- Sequences the 6b/8b trigger-link encoder: decides, per frame slot, whether the encoder emits IDLE, L1A, BC0, RESYNC or a 6-bit data word.
- Buffers 6-bit trigger data in a small FIFO and holds TTC command requests until a slot is free.
- Inserts a startup idle burst and periodic alignment idles for the receiver.
- Sits between the trigger-data formatter/TTC decoder and the encoder's l1a/bc0/resync/idle/sixbit inputs.

Parameters:
- FIFO_DEPTH, 8, data FIFO entries; power of two, 2..64.
- IDLE_PERIOD, 64, frame slots per alignment period; last slot of each period is a forced idle; ≥ 2.
- IDLE_BURST, 4, idle slots sent after reset or link_restart; ≥ 1.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- frame_en  in  1  one frame slot per cycle it is high; encoder consumes outputs at this strobe
- link_restart  in  1  pulse; re-enters startup idle burst
- data_in  in  6  trigger data word
- data_valid  in  1  data_in valid
- data_ready  out  1  FIFO can accept; a word is written when data_valid & data_ready
- l1a_req  in  1  L1A request pulse
- bc0_req  in  1  BC0 request pulse
- resync_req  in  1  resync request pulse
- enc_l1a  out  1  to encoder l1a
- enc_bc0  out  1  to encoder bc0
- enc_resync  out  1  to encoder resync
- enc_idle  out  1  to encoder idle
- enc_sixbit  out  6  to encoder sixbit
- cmd_drop_cnt  out  8  saturating count of coalesced command requests
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): enc_idle=1; enc_l1a/bc0/resync=0; enc_sixbit=0; cmd_drop_cnt=0; FIFO empty; pending flags clear; period counter 0; state STARTUP with burst counter 0; data_ready=1.
- data_ready = (fifo_count != FIFO_DEPTH), combinational from registered count. Write and read in the same cycle when full: the write is refused (ready low); count is unchanged by the read until the next cycle.
- Pending flags l1a_p, bc0_p, resync_p: set on the request; cleared when served.
  - Request in the same cycle its flag is served: flag stays set, no drop.
  - Request while the flag is set and not being served: cmd_drop_cnt += 1, saturating at 255.
  - Simultaneous requests of different types all latch.
- Outputs are registered and update only in cycles with frame_en=1; otherwise they hold. Latency from request/write to first eligible slot is 1 cycle minimum.
- States:
  - STARTUP: each frame_en slot emits idle and increments the burst counter. After IDLE_BURST slots, go to RUN with the period counter at 0. Pending commands and FIFO contents are retained and nothing is dropped.
  - RUN: each frame_en slot increments the period counter, wrapping at IDLE_PERIOD-1 to 0. Slot selection priority:
    1. forced idle, when period counter == IDLE_PERIOD-1
    2. l1a_p
    3. bc0_p
    4. resync_p
    5. FIFO non-empty: pop, enc_sixbit = head word
    6. filler idle
- Exactly one of enc_idle/enc_l1a/enc_bc0/enc_resync is high, or none of them when a data word is output. enc_sixbit = 0 whenever a flag is high.
- link_restart: takes effect the next cycle, in any state. Enters STARTUP with the burst counter cleared and the period counter cleared. FIFO and pending flags are kept. An in-progress output holds until the next frame_en.
- Reset asserted mid-operation: all state returns to reset values immediately; FIFO contents and pending commands are discarded.

Test Plan:
- Reset release, frame_en constant 1, IDLE_BURST=4 → enc_idle=1 for 4 slots; with the FIFO empty, filler idle continues; forced idle lands on slot 63 of each period (period counter = IDLE_PERIOD-1).
- After startup, write words 0x00, 0x15, 0x3F, then raise l1a_req and bc0_req together with the FIFO non-empty → output order L1A, BC0, 0x00, 0x15, 0x3F, then idle.
- Write 9 words with FIFO_DEPTH=8 and frame_en=0 → data_ready low after 8 writes; the 9th is held by the source; fifo_count=8; no overflow.
- Pulse l1a_req on 3 consecutive cycles with frame_en=0 → l1a_p=1, cmd_drop_cnt=2. Issue 300 such extra requests → cmd_drop_cnt=255.
- Command pending while the period counter = IDLE_PERIOD-1 → forced idle emitted first, command in the next slot. Request arriving in the same cycle the flag is served → flag remains set and is served again; no drop.
- link_restart mid-stream with 2 FIFO words and resync pending → 4 idles, then RESYNC, then the 2 words. Assert reset_n low mid-stream → outputs return to idle immediately and fifo_count=0.
